serial_adder: RTL and testbench

//   Bit-serial N-bit adder feeding the team's 1-bit full-adder cell (inputs C_in/a/b, outputs sum/C_out).

---
 rtl/serial_adder.sv | 144 ++++++++++++++
 tb/tb_serial_adder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, carry held in a register, LSB first.
// Optional subtract mode (a - b) is enabled by defining SERIAL_ADDER_SUB_EN.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);
  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (a & c_in) | (b & c_in);
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             busy
`ifdef SERIAL_ADDER_SUB_EN
  ,
  input  logic             sub
`endif
);

  // state | meaning
  // IDLE  | waiting for an operand bundle, in_ready=1
  // RUN   | one bit per cycle through the full adder
  // DONE  | result held on sum/c_out until the consumer takes it
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             fa_sum;
  logic             fa_cout;
  logic             sub_eff;
  logic             accept;
  logic             last_bit;
  logic             consume;
  logic [WIDTH-1:0] b_eff;
  logic             carry_init;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_eff = sub;
`else
  assign sub_eff = 1'b0;
`endif

  // Two's-complement subtract: invert b and inject a carry of one.
  assign b_eff      = sub_eff ? ~b : b;
  assign carry_init = sub_eff ? 1'b1 : c_in;

  full_adder u_fa (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .c_in  (carry),
    .sum   (fa_sum),
    .c_out (fa_cout)
  );

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    last_bit  = 1'b0;
    consume   = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) state_nxt = S_RUN;
      end
      S_RUN: begin
        busy     = 1'b1;
        last_bit = (cnt == CW'(WIDTH - 1));
        if (last_bit) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        consume   = out_ready;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      carry  <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      sum    <= '0;
      c_out  <= 1'b0;
    end else if (accept) begin
      cnt   <= '0;
      carry <= carry_init;
      a_sh  <= a;
      b_sh  <= b_eff;
    end else if (state == S_RUN) begin
      sum_sh <= {fa_sum, sum_sh[WIDTH-1:1]};
      carry  <= fa_cout;
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      if (last_bit) begin
        sum   <= {fa_sum, sum_sh[WIDTH-1:1]};
        c_out <= fa_cout;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed corners, backpressure,
// mid-run reset and random operands against an arithmetic reference model.

module tb_serial_adder;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             c_in = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             busy;
  logic             sub = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .busy      (busy)
`ifdef SERIAL_ADDER_SUB_EN
    ,
    .sub       (sub)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Plain arithmetic: a + b + c_in, or a - b as a + ~b + 1 when subtracting.
  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                           input logic mci, input logic msb);
    logic [WIDTH-1:0] nb;
    nb = ~mb;
    if (msb) return (WIDTH+1)'(ma) + (WIDTH+1)'(nb) + (WIDTH+1)'(1);
    return (WIDTH+1)'(ma) + (WIDTH+1)'(mb) + (WIDTH+1)'(mci);
  endfunction

  task automatic scramble_inputs();
    a    = WIDTH'($urandom);
    b    = WIDTH'($urandom);
    c_in = 1'($urandom);
    sub  = 1'($urandom);
  endtask

  // Caller is #1 after a posedge with the DUT idle; returns in the same phase, DUT idle.
  task automatic do_op(input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob,
                       input logic oci, input logic osb, input int hold);
    logic [WIDTH:0] exp;
    int             lat;
    logic           taken;
    exp = model(oa, ob, oci, osb);
    check("in_ready_idle", in_ready, 1);
    a = oa; b = ob; c_in = oci; sub = osb; in_valid = 1'b1;
    @(posedge clk); #1;
    check("busy_after_accept", busy, 1);
    in_valid = 1'($urandom);
    scramble_inputs();
    lat = 0;
    while (!out_valid && lat < 3 * WIDTH) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, WIDTH);
    check("sum", sum, exp[WIDTH-1:0]);
    check("c_out", c_out, exp[WIDTH]);
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0; in_valid = 1'b1;
      scramble_inputs();
      @(posedge clk); #1;
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_sum", sum, exp[WIDTH-1:0]);
      check("bp_c_out", c_out, exp[WIDTH]);
    end
    taken = 1'b0;
    for (int i = 0; i < 20 && !taken; i++) begin
      out_ready = (i == 19) ? 1'b1 : 1'($urandom);
      in_valid  = 1'b1;
      scramble_inputs();
      taken = out_ready;
      @(posedge clk); #1;
      if (!taken) begin
        check("wait_out_valid", out_valid, 1);
        check("wait_sum", sum, exp[WIDTH-1:0]);
      end
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("post_hs_out_valid", out_valid, 0);
    check("post_hs_busy", busy, 0);
    check("post_hs_in_ready", in_ready, 1);
    check("post_hs_sum_kept", {c_out, sum}, exp);
  endtask

  initial begin
    logic sb;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sum", sum, 0);
    check("rst_c_out", c_out, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(8'h0F, 8'h01, 1'b0, 1'b0, 0);
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, 0);
    do_op(8'h00, 8'h00, 1'b1, 1'b0, 0);
    do_op(8'hFF, 8'hFF, 1'b1, 1'b0, 0);
    do_op(8'h00, 8'h00, 1'b0, 1'b0, 0);
    do_op(8'h3C, 8'h5A, 1'b0, 1'b0, 5);
    do_op(8'h0F, 8'hF1, 1'b0, 1'b0, 0);

    // Reset while RUN is on bit 4: the operation must vanish without a result.
    a = 8'hAB; b = 8'h12; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_sum", sum, 0);
    check("midrst_c_out", c_out, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_busy", busy, 0);
    repeat (2 * WIDTH) @(posedge clk);
    #1;
    check("midrst_no_result", out_valid, 0);
    do_op(8'h22, 8'h11, 1'b0, 1'b0, 0);

`ifdef SERIAL_ADDER_SUB_EN
    do_op(8'h05, 8'h07, 1'b0, 1'b1, 0);
    do_op(8'h07, 8'h05, 1'b1, 1'b1, 0);
    do_op(8'h07, 8'h05, 1'b1, 1'b0, 0);
`endif

    for (int n = 0; n < 300; n++) begin
`ifdef SERIAL_ADDER_SUB_EN
      sb = 1'($urandom);
`else
      sb = 1'b0;
`endif
      do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), sb, int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
